// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select, samples y after DWELL cycles per channel, hands out 4-bit frames
//
// Ports:
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    start        level, begins a scan when idle
//    cont         continuous mode, looked at when a frame is accepted
//    y            mux output being scanned
//    s            mux select
//    busy         high whenever not idle
//    frame        frame[n] = y sampled while s == n
//    frame_valid  frame holds a completed, unaccepted scan
//    frame_ready  downstream accept
//    frame_par    even parity of frame when SCAN_PARITY_EN is defined, else 0
//
// Build option: define SCAN_PARITY_EN to build the frame parity register.
module mux_scan_ctrl #(
   parameter int DWELL = 4,
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cont,
   input  logic       y,
   output logic [1:0] s,
   output logic       busy,
   output logic [3:0] frame,
   output logic       frame_valid,
   input  logic       frame_ready,
   output logic       frame_par
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t           r_state, w_state_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [1:0]       r_s, w_s_nx;
   logic [2:0]       r_shadow, w_shadow_nx, w_mask;
   logic [3:0]       r_frame, w_frame_nx;
   logic             r_valid, w_valid_nx, r_busy, w_dwell_end;
   assign w_dwell_end = r_cnt == CNT_W'(DWELL - 1);
   // channel 3 shifts out of the 3-bit mask, so its sample goes straight into frame
   assign w_mask = 3'(1) << r_s;
   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      w_s_nx      = r_s;
      w_shadow_nx = r_shadow;
      w_frame_nx  = r_frame;
      w_valid_nx  = r_valid;
      case (r_state)
         IDLE: begin
            w_s_nx   = '0;
            w_cnt_nx = '0;
            if (start) w_state_nx = SCAN;
         end
         SCAN: begin
            w_cnt_nx = w_dwell_end ? '0 : r_cnt + CNT_W'(1);
            if (w_dwell_end) begin
               w_shadow_nx = (r_shadow & ~w_mask) | ({3{y}} & w_mask);
               w_s_nx      = r_s + 2'd1;
               if (r_s == 2'd3) begin
                  w_frame_nx = {y, r_shadow};
                  w_valid_nx = 1'b1;
                  w_state_nx = DONE;
               end
            end
         end
         DONE: begin
            if (r_valid && frame_ready) begin
               w_valid_nx = 1'b0;
               w_cnt_nx   = '0;
               w_state_nx = cont ? SCAN : IDLE;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_s      <= '0;
         r_shadow <= '0;
         r_frame  <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_s      <= w_s_nx;
         r_shadow <= w_shadow_nx;
         r_frame  <= w_frame_nx;
         r_valid  <= w_valid_nx;
         r_busy   <= w_state_nx != IDLE;
      end
   end
`ifdef SCAN_PARITY_EN
   logic r_par, w_last;
   assign w_last = r_state == SCAN && w_dwell_end && r_s == 2'd3;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_par <= 1'b0;
      else if (w_last) r_par <= ^{y, r_shadow};
   end
   assign frame_par = r_par;
`else
   assign frame_par = 1'b0;
`endif
   assign s           = r_s;
   assign busy        = r_busy;
   assign frame       = r_frame;
   assign frame_valid = r_valid;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed and randomized checks of mux_scan_ctrl at DWELL=4 and DWELL=1
module tb_mux_scan_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0, frame_ready = 1'b0;
   logic [3:0] inp = 4'd0;
   logic [1:0] s_o [2];
   logic       busy_o [2], fv_o [2], par_o [2], y_i [2];
   logic [3:0] frame_o [2];
   int         total = 0, bad = 0;

   always #5 clk = ~clk;

   // behavioural 4:1 mux in front of each controller
   assign y_i[0] = inp[s_o[0]];
   assign y_i[1] = inp[s_o[1]];

   mux_scan_ctrl #(.DWELL(4), .CNT_W(8)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .y(y_i[0]), .s(s_o[0]),
      .busy(busy_o[0]), .frame(frame_o[0]), .frame_valid(fv_o[0]),
      .frame_ready(frame_ready), .frame_par(par_o[0]));

   mux_scan_ctrl #(.DWELL(1), .CNT_W(3)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .y(y_i[1]), .s(s_o[1]),
      .busy(busy_o[1]), .frame(frame_o[1]), .frame_valid(fv_o[1]),
      .frame_ready(frame_ready), .frame_par(par_o[1]));

   function automatic logic exp_par(input logic [3:0] f);
`ifdef SCAN_PARITY_EN
      return ^f;
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; start = 1'b0; cont = 1'b0; frame_ready = 1'b0; inp = 4'd0;
      tick; tick;
      rst_n = 1'b1;
   endtask

   // raises start so that the next edge is E0; returns just after E0
   task automatic kick;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      total++; if (busy_o[0] !== 1'b0 || s_o[0] !== 2'd0 || fv_o[0] !== 1'b0 || frame_o[0] !== 4'd0) begin
         bad++; $display("FAIL reset_idle: busy=%b s=%0d fv=%b frame=%b want 0 0 0 0000", busy_o[0], s_o[0], fv_o[0], frame_o[0]);
      end
      inp = 4'b1101; frame_ready = 1'b0;
      kick;
      repeat (16) tick;
      total++; if (fv_o[0] !== 1'b1 || frame_o[0] !== 4'b1101) begin
         bad++; $display("FAIL reset_prefill: fv=%b frame=%b want 1 1101", fv_o[0], frame_o[0]);
      end
      frame_ready = 1'b1; cont = 1'b1;
      tick;
      frame_ready = 1'b0;
      repeat (8) tick;
      total++; if (s_o[0] !== 2'd2 || busy_o[0] !== 1'b1) begin
         bad++; $display("FAIL reset_midscan_s: s=%0d busy=%b want 2 1", s_o[0], busy_o[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if (s_o[0] !== 2'd0 || busy_o[0] !== 1'b0 || fv_o[0] !== 1'b0 || frame_o[0] !== 4'd0 || par_o[0] !== 1'b0) begin
         bad++; $display("FAIL reset_async: s=%0d busy=%b fv=%b frame=%b par=%b want 0 0 0 0000 0", s_o[0], busy_o[0], fv_o[0], frame_o[0], par_o[0]);
      end
      tick;
      rst_n = 1'b1; cont = 1'b0;
   endtask

   task automatic test_single_shot;
      do_reset;
      inp = 4'b1101; frame_ready = 1'b1;
      kick;
      for (int k = 0; k < 16; k++) begin
         total++; if (s_o[0] !== 2'(k / 4) || busy_o[0] !== 1'b1 || fv_o[0] !== 1'b0) begin
            bad++; $display("FAIL single_step%0d: s=%0d busy=%b fv=%b want %0d 1 0", k, s_o[0], busy_o[0], fv_o[0], k / 4);
         end
         tick;
      end
      total++; if (fv_o[0] !== 1'b1 || frame_o[0] !== 4'b1101 || s_o[0] !== 2'd0 || par_o[0] !== exp_par(4'b1101)) begin
         bad++; $display("FAIL single_frame: fv=%b frame=%b s=%0d par=%b want 1 1101 0 %b", fv_o[0], frame_o[0], s_o[0], par_o[0], exp_par(4'b1101));
      end
      tick;
      total++; if (busy_o[0] !== 1'b0 || s_o[0] !== 2'd0 || fv_o[0] !== 1'b0) begin
         bad++; $display("FAIL single_idle: busy=%b s=%0d fv=%b want 0 0 0", busy_o[0], s_o[0], fv_o[0]);
      end
   endtask

   task automatic test_backpressure;
      do_reset;
      inp = 4'b1101; frame_ready = 1'b0;
      kick;
      repeat (16) tick;
      inp = 4'b0000;
      for (int k = 0; k < 10; k++) begin
         total++; if (fv_o[0] !== 1'b1 || frame_o[0] !== 4'b1101 || s_o[0] !== 2'd0 || busy_o[0] !== 1'b1) begin
            bad++; $display("FAIL bp_hold%0d: fv=%b frame=%b s=%0d busy=%b want 1 1101 0 1", k, fv_o[0], frame_o[0], s_o[0], busy_o[0]);
         end
         tick;
      end
      frame_ready = 1'b1;
      tick;
      total++; if (fv_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
         bad++; $display("FAIL bp_release: fv=%b busy=%b want 0 0", fv_o[0], busy_o[0]);
      end
   endtask

   task automatic test_continuous;
      logic efv, eb;
      do_reset;
      inp = 4'b1010; cont = 1'b1; frame_ready = 1'b1;
      kick;
      for (int k = 1; k <= 20; k++) begin
         tick;
         efv = (k == 4 || k == 9 || k == 14);
         eb  = k < 15;
         total++; if (fv_o[1] !== efv || busy_o[1] !== eb || (efv && frame_o[1] !== 4'b1010)) begin
            bad++; $display("FAIL cont_E%0d: fv=%b busy=%b frame=%b want %b %b 1010", k, fv_o[1], busy_o[1], frame_o[1], efv, eb);
         end
         if (k == 11) cont = 1'b0;
      end
   endtask

   task automatic test_start_busy;
      do_reset;
      inp = 4'b0110; frame_ready = 1'b0;
      kick;
      for (int k = 1; k <= 16; k++) begin
         start = (k == 4 || k == 5);
         tick;
         total++; if ((k < 16 && (fv_o[0] !== 1'b0 || s_o[0] !== 2'(k / 4))) || (k == 16 && (fv_o[0] !== 1'b1 || frame_o[0] !== 4'b0110))) begin
            bad++; $display("FAIL busy_start_E%0d: fv=%b s=%0d frame=%b", k, fv_o[0], s_o[0], frame_o[0]);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_parity;
      logic [3:0] pats [2];
      logic       want;
      pats[0] = 4'b1101; pats[1] = 4'b1001;
      do_reset;
      frame_ready = 1'b0;
      for (int p = 0; p < 2; p++) begin
         inp = pats[p];
         kick;
         repeat (16) tick;
`ifdef SCAN_PARITY_EN
         want = (p == 0);
`else
         want = 1'b0;
`endif
         total++; if (fv_o[0] !== 1'b1 || frame_o[0] !== pats[p] || par_o[0] !== want) begin
            bad++; $display("FAIL parity%0d: fv=%b frame=%b par=%b want 1 %b %b", p, fv_o[0], frame_o[0], par_o[0], pats[p], want);
         end
         frame_ready = 1'b1;
         tick;
         frame_ready = 1'b0;
      end
   endtask

   // reference: scan time t counts edges since the scan began; channel n is read at t = (n+1)*D
   task automatic test_random(input int d, input int D);
      bit         mb = 0, ms = 0, mv = 0;
      int         t = 0, es;
      logic [3:0] samp = 4'd0, mf = 4'd0;
      logic       mp = 1'b0;
      do_reset;
      for (int n = 0; n < 400; n++) begin
         start = ($urandom_range(0, 3) == 0);
         cont = 1'($urandom);
         frame_ready = ($urandom_range(0, 2) != 0);
         inp = 4'($urandom);
         if (!mb) begin
            if (start) begin mb = 1; ms = 1; t = 0; end
         end else if (ms) begin
            t++;
            if (t % D == 0) samp[t / D - 1] = inp[t / D - 1];
            if (t == 4 * D) begin mf = samp; mv = 1; ms = 0; mp = exp_par(samp); end
         end else if (frame_ready) begin
            mv = 0;
            if (cont) begin ms = 1; t = 0; end
            else mb = 0;
         end
         tick;
         es = ms ? t / D : 0;
         total++; if (s_o[d] !== 2'(es) || busy_o[d] !== mb || fv_o[d] !== mv || frame_o[d] !== mf || par_o[d] !== mp) begin
            bad++; $display("FAIL rand_D%0d_c%0d: s=%0d busy=%b fv=%b frame=%b par=%b want %0d %b %b %b %b",
                            D, n, s_o[d], busy_o[d], fv_o[d], frame_o[d], par_o[d], es, mb, mv, mf, mp);
         end
      end
   endtask

   initial begin
      test_reset;
      test_single_shot;
      test_backpressure;
      test_continuous;
      test_start_busy;
      test_parity;
      test_random(0, 4);
      test_random(1, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
